ppu_frame_writer: RTL and testbench

Downstream consumer of the PPU pixel pipeline. Takes the 2-bit background colour index stream (`px_in`/`px_valid`) and the PPU mode, then maps each index through the BGP palette. Each shaded pixel is written at its (x, y) position into a 160x144 2-bit framebuffer RAM, which the display scan-out reads from the other port. The block also tracks line and frame boundaries, reports pixel-count errors, and optionally double-buffers the frame.

---
 rtl/ppu_frame_writer.sv | 213 +++++++++++++++++++++
 tb/tb_ppu_frame_writer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_frame_writer.sv
// ppu_frame_writer: maps the PPU background colour-index stream through the
// BGP palette and writes each shade into a H_PIXELS x V_LINES 2-bit
// framebuffer. It tracks line and frame boundaries and flags lines that
// carried too many or too few pixels.
//
// Optional feature macro: PPU_FB_DOUBLE_BUFFER_EN
//   defined   - two framebuffer banks. The write bank toggles at every
//               V-blank entry and scan-out reads the other bank.
//   undefined - a single bank. The bank bit and rd_bank are tied to 0.
module ppu_frame_writer #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lcd_en,
    input  logic [1:0]        ppu_mode,
    input  logic [1:0]        px_in,
    input  logic              px_valid,
    input  logic [7:0]        bgp,
    input  logic              err_clr,
    output logic              fb_we,
    output logic [ADDR_W:0]   fb_waddr,
    output logic [1:0]        fb_wdata,
    output logic              rd_bank,
    output logic              frame_done,
    output logic [7:0]        line_cnt,
    output logic              err_overrun,
    output logic              err_underrun
);

    localparam int X_W = $clog2(H_PIXELS + 1);

    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_SCAN   = 2'd2;
    localparam logic [1:0] MODE_DRAW   = 2'd3;

    localparam logic [X_W-1:0]    X_FULL     = X_W'(H_PIXELS);
    localparam logic [7:0]        LAST_LINE  = 8'(V_LINES - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(H_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_DRAW,
        S_DRAW,
        S_VBL
    } state_t;

    state_t state;
    state_t state_next;

    // x saturates at H_PIXELS: that value marks a full line,
    // and any further pixels on the line are dropped.
    logic [X_W-1:0]    x;
    logic [7:0]        y;
    logic [ADDR_W-1:0] line_base;

    logic accept;
    logic line_end;
    logic vbl_entry;
    logic write_ok;
    logic drop;
    logic bank_bit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus per-cycle events: pixel acceptance, line end and
    // V-blank entry. A low lcd_en overrides every other condition.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        line_end   = 1'b0;
        vbl_entry  = 1'b0;
        if (!lcd_en) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_WAIT_DRAW;
                end
                S_WAIT_DRAW: begin
                    if (ppu_mode == MODE_DRAW) begin
                        state_next = S_DRAW;
                    end else if (ppu_mode == MODE_VBLANK) begin
                        state_next = S_VBL;
                        vbl_entry  = 1'b1;
                    end
                end
                S_DRAW: begin
                    if (ppu_mode == MODE_DRAW) begin
                        accept = px_valid;
                    end else begin
                        line_end = 1'b1;
                        if (y == LAST_LINE) begin
                            state_next = S_VBL;
                            vbl_entry  = 1'b1;
                        end else begin
                            state_next = S_WAIT_DRAW;
                        end
                    end
                end
                S_VBL: begin
                    if (ppu_mode == MODE_SCAN || ppu_mode == MODE_DRAW) begin
                        state_next = S_WAIT_DRAW;
                    end
                    accept = px_valid && (ppu_mode == MODE_DRAW);
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign write_ok = accept && (x < X_FULL);
    assign drop     = accept && (x == X_FULL);

`ifdef PPU_FB_DOUBLE_BUFFER_EN
    logic wr_bank;

    // The write bank flips on every V-blank entry, so scan-out always
    // reads the last finished frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
        end else if (vbl_entry) begin
            wr_bank <= ~wr_bank;
        end
    end

    assign bank_bit = wr_bank;
    assign rd_bank  = ~wr_bank;
`else
    assign bank_bit = 1'b0;
    assign rd_bank  = 1'b0;
`endif

    // Framebuffer write port: one registered write per accepted pixel.
    // The palette lookup uses the bgp value sampled with the pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we    <= 1'b0;
            fb_waddr <= '0;
            fb_wdata <= 2'd0;
        end else begin
            fb_we <= write_ok;
            if (write_ok) begin
                fb_waddr <= {bank_bit, line_base + ADDR_W'(x)};
                fb_wdata <= bgp[{px_in, 1'b0} +: 2];
            end
        end
    end

    // Position counters. The line base advances by one line's width, so
    // addresses are formed without a multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= 8'd0;
            line_base <= '0;
        end else if (!lcd_en || state == S_IDLE || vbl_entry) begin
            x         <= '0;
            y         <= 8'd0;
            line_base <= '0;
        end else if (line_end) begin
            x         <= '0;
            y         <= y + 8'd1;
            line_base <= line_base + LINE_STEP;
        end else if (write_ok) begin
            x <= x + X_W'(1);
        end
    end

    // Frame-done pulse, high for the first cycle in V-blank.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= vbl_entry;
        end
    end

    // Sticky error flags. If a set condition and err_clr occur together,
    // the set condition wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            if (drop) begin
                err_overrun <= 1'b1;
            end else if (err_clr) begin
                err_overrun <= 1'b0;
            end
            if (line_end && (x < X_FULL)) begin
                err_underrun <= 1'b1;
            end else if (err_clr) begin
                err_underrun <= 1'b0;
            end
        end
    end

    assign line_cnt = y;

endmodule

// File: tb/tb_ppu_frame_writer.sv
// Testbench for ppu_frame_writer. A line-level reference model queues every
// expected framebuffer write. A monitor pops one entry and compares it
// whenever fb_we is high.
module tb_ppu_frame_writer;

    localparam int H  = 160;
    localparam int V  = 144;
    localparam int AW = 15;

`ifdef PPU_FB_DOUBLE_BUFFER_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          lcd_en;
    logic [1:0]    ppu_mode;
    logic [1:0]    px_in;
    logic          px_valid;
    logic [7:0]    bgp;
    logic          err_clr;
    logic          fb_we;
    logic [AW:0]   fb_waddr;
    logic [1:0]    fb_wdata;
    logic          rd_bank;
    logic          frame_done;
    logic [7:0]    line_cnt;
    logic          err_overrun;
    logic          err_underrun;

    ppu_frame_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_en       (lcd_en),
        .ppu_mode     (ppu_mode),
        .px_in        (px_in),
        .px_valid     (px_valid),
        .bgp          (bgp),
        .err_clr      (err_clr),
        .fb_we        (fb_we),
        .fb_waddr     (fb_waddr),
        .fb_wdata     (fb_wdata),
        .rd_bank      (rd_bank),
        .frame_done   (frame_done),
        .line_cnt     (line_cnt),
        .err_overrun  (err_overrun),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int frame_done_seen = 0;

    logic [AW+2:0] exp_q[$];
    int exp_line = 0;
    int exp_x    = 0;
    bit exp_bank = 1'b0;
    bit exp_over = 1'b0;
    bit exp_under = 1'b0;

    function automatic logic [1:0] shade(input logic [7:0] pal, input logic [1:0] idx);
        logic [7:0] t;
        t = pal >> (2 * idx);
        return t[1:0];
    endfunction

    function automatic int exp_rd();
        return (DBL && !exp_bank) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DRAW cycle carrying a valid pixel; the model records what it should write
    task automatic drive_pixel(input logic [1:0] idx, input logic [7:0] pal);
        logic [AW:0] a;
        ppu_mode = 2'd3;
        px_valid = 1'b1;
        px_in    = idx;
        bgp      = pal;
        if (lcd_en) begin
            if (exp_x < H) begin
                a = {(DBL ? exp_bank : 1'b0), AW'(exp_line * H + exp_x)};
                exp_q.push_back({a, shade(pal, idx)});
                exp_x++;
            end else begin
                exp_over = 1'b1;
            end
        end
        tick();
    endtask

    // Model of a line end, including frame wrap
    task automatic model_line_end();
        if (exp_x < H) exp_under = 1'b1;
        exp_x = 0;
        exp_line++;
        if (exp_line == V) begin
            exp_line = 0;
            exp_bank = ~exp_bank;
        end
    endtask

    // One full scanline: SCAN, DRAW with npix pixels, then end_mode.
    // sel 0: indices 0..3 with bgp E4, sel 1: same with bgp 1B, sel 2: random.
    task automatic applyStimulus(input int npix, input int sel, input bit gaps, input logic [1:0] end_mode);
        int n;
        ppu_mode = 2'd2;
        px_valid = 1'($urandom_range(0, 1));
        px_in    = 2'($urandom);
        tick();
        tick();
        ppu_mode = 2'd3;
        px_valid = 1'b0;
        tick();
        n = 0;
        while (n < npix) begin
            if (gaps && ($urandom_range(0, 7) == 0)) begin
                ppu_mode = 2'd3;
                px_valid = 1'b0;
                px_in    = 2'($urandom);
                tick();
            end else begin
                case (sel)
                    0:       drive_pixel(2'(n % 4), 8'hE4);
                    1:       drive_pixel(2'(n % 4), 8'h1B);
                    default: drive_pixel(2'($urandom), 8'($urandom));
                endcase
                n++;
            end
        end
        ppu_mode = end_mode;
        px_valid = 1'b1;
        px_in    = 2'($urandom);
        model_line_end();
        tick();
        px_valid = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: scoreboard pop on every write, frame_done pulse counting
    always @(negedge clk) begin
        logic [AW+2:0] e;
        if (frame_done) frame_done_seen++;
        if (fb_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_write: got addr %0d expected no write", fb_waddr);
            end else begin
                e = exp_q.pop_front();
                checkOutput("fb_waddr", int'(fb_waddr), int'(e[AW+2:2]));
                checkOutput("fb_wdata", int'(fb_wdata), int'(e[1:0]));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        lcd_en   = 1'b0;
        ppu_mode = 2'd0;
        px_in    = 2'd0;
        px_valid = 1'b0;
        bgp      = 8'hE4;
        err_clr  = 1'b0;
        repeat (3) tick();

        checkOutput("reset_fb_we", int'(fb_we), 0);
        checkOutput("reset_fb_waddr", int'(fb_waddr), 0);
        checkOutput("reset_fb_wdata", int'(fb_wdata), 0);
        checkOutput("reset_frame_done", int'(frame_done), 0);
        checkOutput("reset_line_cnt", int'(line_cnt), 0);
        checkOutput("reset_err_overrun", int'(err_overrun), 0);
        checkOutput("reset_err_underrun", int'(err_underrun), 0);
        checkOutput("reset_rd_bank", int'(rd_bank), exp_rd());

        rst    = 1'b0;
        lcd_en = 1'b1;
        tick();

        // Palette mapping lines
        applyStimulus(160, 0, 1'b0, 2'd0);
        checkOutput("line0_line_cnt", int'(line_cnt), 1);
        checkOutput("line0_overrun", int'(err_overrun), int'(exp_over));
        checkOutput("line0_underrun", int'(err_underrun), int'(exp_under));
        applyStimulus(160, 1, 1'b0, 2'd0);
        checkOutput("line1_line_cnt", int'(line_cnt), 2);

        // Overrun, then clear
        applyStimulus(165, 2, 1'b1, 2'd0);
        checkOutput("overrun_set", int'(err_overrun), int'(exp_over));
        checkOutput("overrun_no_underrun", int'(err_underrun), int'(exp_under));
        err_clr = 1'b1;
        tick();
        err_clr  = 1'b0;
        exp_over = 1'b0;
        checkOutput("overrun_cleared", int'(err_overrun), 0);

        // Underrun, then clear
        applyStimulus(100, 2, 1'b1, 2'd0);
        checkOutput("underrun_set", int'(err_underrun), int'(exp_under));
        checkOutput("underrun_line_cnt", int'(line_cnt), 4);
        err_clr = 1'b1;
        tick();
        err_clr   = 1'b0;
        exp_under = 1'b0;
        checkOutput("underrun_cleared", int'(err_underrun), 0);

        // Remaining lines of the frame
        for (int l = 4; l < V - 1; l++) begin
            applyStimulus(160, 2, 1'b1, 2'd0);
            checkOutput("mid_line_cnt", int'(line_cnt), exp_line);
        end
        checkOutput("no_early_frame_done", frame_done_seen, 0);
        applyStimulus(160, 2, 1'b1, 2'd1);
        repeat (5) tick();
        checkOutput("frame_done_count", frame_done_seen, 1);
        checkOutput("frame_line_cnt", int'(line_cnt), 0);
        checkOutput("frame_rd_bank", int'(rd_bank), exp_rd());
        checkOutput("frame_no_underrun", int'(err_underrun), 0);

        // Next frame, first line overruns so flags are set before disable
        applyStimulus(165, 2, 1'b1, 2'd0);
        checkOutput("f1_line_cnt", int'(line_cnt), 1);
        checkOutput("f1_overrun", int'(err_overrun), int'(exp_over));

        // Disable mid-line after 50 pixels
        ppu_mode = 2'd2;
        tick();
        tick();
        ppu_mode = 2'd3;
        px_valid = 1'b0;
        tick();
        for (int i = 0; i < 50; i++) drive_pixel(2'($urandom), 8'($urandom));
        lcd_en = 1'b0;
        for (int i = 0; i < 3; i++) drive_pixel(2'($urandom), 8'($urandom));
        checkOutput("disable_fb_we", int'(fb_we), 0);
        exp_line = 0;
        exp_x    = 0;
        ppu_mode = 2'd0;
        px_valid = 1'b0;
        repeat (3) tick();
        checkOutput("disable_no_frame_done", frame_done_seen, 1);
        checkOutput("disable_line_cnt", int'(line_cnt), 0);
        checkOutput("disable_overrun_kept", int'(err_overrun), int'(exp_over));
        checkOutput("disable_rd_bank", int'(rd_bank), exp_rd());

        // Re-enable and draw from address 0
        lcd_en = 1'b1;
        tick();
        applyStimulus(160, 0, 1'b1, 2'd0);
        checkOutput("reenable_line_cnt", int'(line_cnt), 1);

        repeat (5) tick();
        checkOutput("writes_outstanding", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
